my_encoder_drain: RTL and testbench

Sequential 32-to-5 encoder that is the inverse of the register-file write-select decoder. It accepts a 32-bit multi-hot select vector over a valid/ready handshake and emits the 5-bit index of every set bit, one index per handshake, in priority order. It sits between hazard/scoreboard logic, which produces register bitmasks, and consumers that need register numbers, such as writeback replay and debug dump.

---
 rtl/my_encoder_drain.sv | 138 +++++++++++++
 tb/tb_my_encoder_drain.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/my_encoder_drain.sv
`default_nettype none
// ============================================================================
//  Module      : my_encoder_drain
//  Description : Sequential 32-to-5 encoder. Accepts a multi-hot 32-bit
//                register select vector over valid/ready and emits the 5-bit
//                index of every set bit, one per output handshake, in
//                priority order (lowest first when LSB_FIRST=1, else highest).
//
//  Ports:
//    clock       in   1   rising-edge clock
//    ctrl_reset  in   1   asynchronous active-low reset
//    in_valid    in   1   upstream vector available on in_vec
//    in_ready    out  1   block idle and able to accept a vector
//    in_vec      in  32   multi-hot select vector (bit k = register k)
//    out_valid   out  1   out_idx holds a valid index
//    out_ready   in   1   downstream consumes out_idx this cycle
//    out_idx     out  5   encoded register number
//    out_last    out  1   presented index is the final set bit
//    remaining   out  6   set bits still pending, including the presented one
//    zero_drop   out  1   one-cycle pulse: all-zero vector accepted/discarded
//
//  Revision    : 1.0  initial release
// ============================================================================
module my_encoder_drain #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_vec,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_idx,
    output logic        out_last,
    output logic [5:0]  remaining,
    output logic        zero_drop
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pending;

    logic [31:0] w_cleared;
    logic [31:0] w_src;
    logic [4:0]  w_enc;
    logic [5:0]  w_pop;

    // Pending bits after the currently presented index is consumed.
    assign w_cleared = r_pending & ~(32'd1 << out_idx);

    // All outputs are registered, so the next-cycle values are computed from
    // the vector that will be pending after this edge: the incoming vector
    // when idle, otherwise the pending set minus the emitted bit.
    assign w_src = (r_state == S_IDLE) ? in_vec : w_cleared;

    generate
        if (LSB_FIRST) begin : g_lsb_first
            always_comb begin
                w_enc = 5'd0;
                for (int i = 31; i >= 0; i--) begin
                    if (w_src[i]) w_enc = 5'(i);
                end
            end
        end else begin : g_msb_first
            always_comb begin
                w_enc = 5'd0;
                for (int i = 0; i < 32; i++) begin
                    if (w_src[i]) w_enc = 5'(i);
                end
            end
        end
    endgenerate

    always_comb begin
        w_pop = 6'd0;
        for (int i = 0; i < 32; i++) begin
            w_pop = w_pop + 6'(w_src[i]);
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_state   <= S_IDLE;
            r_pending <= 32'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_idx   <= 5'd0;
            out_last  <= 1'b0;
            remaining <= 6'd0;
            zero_drop <= 1'b0;
        end else begin
            zero_drop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (in_vec != 32'd0) begin
                            r_pending <= in_vec;
                            r_state   <= S_DRAIN;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_idx   <= w_enc;
                            out_last  <= (w_pop == 6'd1);
                            remaining <= w_pop;
                        end else begin
                            zero_drop <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            r_pending <= 32'd0;
                            r_state   <= S_IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_idx   <= 5'd0;
                            out_last  <= 1'b0;
                            remaining <= 6'd0;
                        end else begin
                            r_pending <= w_cleared;
                            out_idx   <= w_enc;
                            out_last  <= (w_pop == 6'd1);
                            remaining <= w_pop;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_my_encoder_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_my_encoder_drain
//  Description : Self-checking bench. Drives an LSB-first and an MSB-first
//                instance with identical stimulus and compares both against a
//                queue-based reference model, plus table vectors and
//                hand-written corner-case sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_my_encoder_drain;

    logic        clock;
    logic        ctrl_reset;
    logic        in_valid;
    logic [31:0] in_vec;
    logic        out_ready;

    logic        l_in_ready, l_out_valid, l_out_last, l_zero_drop;
    logic [4:0]  l_out_idx;
    logic [5:0]  l_remaining;
    logic        m_in_ready, m_out_valid, m_out_last, m_zero_drop;
    logic [4:0]  m_out_idx;
    logic [5:0]  m_remaining;

    int checks;
    int failures;

    // Reference model: list of indices still to be emitted, in emission order.
    int ql[$];
    int qm[$];
    bit zd;

    my_encoder_drain #(.LSB_FIRST(1'b1)) dut_lsb (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .in_valid(in_valid), .in_ready(l_in_ready), .in_vec(in_vec),
        .out_valid(l_out_valid), .out_ready(out_ready), .out_idx(l_out_idx),
        .out_last(l_out_last), .remaining(l_remaining), .zero_drop(l_zero_drop)
    );

    my_encoder_drain #(.LSB_FIRST(1'b0)) dut_msb (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .in_valid(in_valid), .in_ready(m_in_ready), .in_vec(in_vec),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_idx(m_out_idx),
        .out_last(m_out_last), .remaining(m_remaining), .zero_drop(m_zero_drop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        ql.delete();
        qm.delete();
        zd = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] vec, input logic rdy);
        bit zd_n;
        zd_n = 1'b0;
        if (ql.size() == 0) begin
            if (v) begin
                if (vec == 32'd0) zd_n = 1'b1;
                else begin
                    for (int i = 0; i < 32; i++) begin
                        if (vec[i]) begin
                            ql.push_back(i);
                            qm.push_front(i);
                        end
                    end
                end
            end
        end else if (rdy) begin
            void'(ql.pop_front());
            void'(qm.pop_front());
        end
        zd = zd_n;
    endtask

    task automatic check_model();
        int n;
        n = ql.size();
        chk("lsb_in_ready",  32'(l_in_ready),  32'(n == 0));
        chk("lsb_out_valid", 32'(l_out_valid), 32'(n != 0));
        chk("lsb_out_idx",   32'(l_out_idx),   (n != 0) ? 32'(ql[0]) : 32'd0);
        chk("lsb_out_last",  32'(l_out_last),  32'(n == 1));
        chk("lsb_remaining", 32'(l_remaining), 32'(n));
        chk("lsb_zero_drop", 32'(l_zero_drop), 32'(zd));
        chk("msb_in_ready",  32'(m_in_ready),  32'(n == 0));
        chk("msb_out_valid", 32'(m_out_valid), 32'(n != 0));
        chk("msb_out_idx",   32'(m_out_idx),   (n != 0) ? 32'(qm[0]) : 32'd0);
        chk("msb_out_last",  32'(m_out_last),  32'(n == 1));
        chk("msb_remaining", 32'(m_remaining), 32'(n));
        chk("msb_zero_drop", 32'(m_zero_drop), 32'(zd));
    endtask

    // Apply inputs, advance one edge, then sample #1 after the edge.
    task automatic cycle(input logic v, input logic [31:0] vec, input logic rdy);
        in_valid  = v;
        in_vec    = vec;
        out_ready = rdy;
        @(posedge clock);
        if (!ctrl_reset) model_reset();
        else model_step(v, vec, rdy);
        #1;
        check_model();
    endtask

    typedef struct {
        logic [31:0] vec;
        int          first_lsb;
        int          first_msb;
        int          count;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n;
        int guard;
        logic [31:0] rv;
        checks   = 0;
        failures = 0;
        model_reset();

        tbl[0] = '{32'h8000_0000, 31, 31, 1};
        tbl[1] = '{32'h0000_0025,  0,  5, 3};
        tbl[2] = '{32'h0000_0001,  0,  0, 1};
        tbl[3] = '{32'hFFFF_FFFF,  0, 31, 32};
        tbl[4] = '{32'h8000_0001,  0, 31, 2};
        tbl[5] = '{32'h0000_00F0,  4,  7, 4};
        tbl[6] = '{32'h0000_0000,  0,  0, 0};

        // Reset held with random inputs.
        ctrl_reset = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'($urandom), $urandom, 1'($urandom));
        chk("reset_in_ready",  32'(l_in_ready), 32'd1);
        chk("reset_out_valid", 32'(l_out_valid), 32'd0);
        chk("reset_out_idx",   32'(l_out_idx), 32'd0);
        chk("reset_remaining", 32'(l_remaining), 32'd0);
        chk("reset_zero_drop", 32'(l_zero_drop), 32'd0);
        ctrl_reset = 1'b1;
        cycle(1'b0, 32'd0, 1'b0);

        // Table-driven vectors.
        for (int t = 0; t < 7; t++) begin
            cycle(1'b1, tbl[t].vec, 1'b1);
            chk("tbl_valid",     32'(l_out_valid), 32'(tbl[t].count != 0));
            chk("tbl_first_lsb", 32'(l_out_idx),   32'(tbl[t].first_lsb));
            chk("tbl_first_msb", 32'(m_out_idx),   32'(tbl[t].first_msb));
            chk("tbl_remaining", 32'(l_remaining), 32'(tbl[t].count));
            chk("tbl_zero_drop", 32'(l_zero_drop), 32'(tbl[t].count == 0));
            n = 0;
            guard = 0;
            while (l_out_valid && guard < 40) begin
                n++;
                guard++;
                cycle(1'b0, 32'd0, 1'b1);
            end
            chk("tbl_drain_len", 32'(n), 32'(tbl[t].count));
        end

        // Explicit 0x25 sequence.
        cycle(1'b1, 32'h0000_0025, 1'b1);
        chk("seq25_idx0", 32'(l_out_idx), 32'd0); chk("seq25_rem0", 32'(l_remaining), 32'd3);
        chk("seq25_last0", 32'(l_out_last), 32'd0); chk("seq25_msb0", 32'(m_out_idx), 32'd5);
        cycle(1'b1, 32'hFFFF_FFFF, 1'b1);
        chk("seq25_idx1", 32'(l_out_idx), 32'd2); chk("seq25_rem1", 32'(l_remaining), 32'd2);
        chk("seq25_last1", 32'(l_out_last), 32'd0); chk("seq25_msb1", 32'(m_out_idx), 32'd2);
        cycle(1'b1, 32'hFFFF_FFFF, 1'b1);
        chk("seq25_idx2", 32'(l_out_idx), 32'd5); chk("seq25_rem2", 32'(l_remaining), 32'd1);
        chk("seq25_last2", 32'(l_out_last), 32'd1); chk("seq25_msb2", 32'(m_out_idx), 32'd0);
        cycle(1'b0, 32'd0, 1'b1);
        chk("seq25_idle", 32'(l_in_ready), 32'd1);

        // Two consecutive zero accepts: zero_drop high two cycles, then low.
        cycle(1'b1, 32'd0, 1'b1);
        chk("zd_first", 32'(l_zero_drop), 32'd1);
        cycle(1'b1, 32'd0, 1'b1);
        chk("zd_second", 32'(l_zero_drop), 32'd1);
        chk("zd_no_valid", 32'(l_out_valid), 32'd0);
        cycle(1'b0, 32'd0, 1'b1);
        chk("zd_clear", 32'(l_zero_drop), 32'd0);

        // Full vector under random backpressure, in_valid held high.
        cycle(1'b1, 32'hFFFF_FFFF, 1'b0);
        guard = 0;
        while (l_out_valid && guard < 400) begin
            guard++;
            cycle(1'b1, 32'hFFFF_FFFF, 1'($urandom_range(0, 1)));
        end
        chk("bp_done", 32'(guard < 400), 32'd1);
        cycle(1'b0, 32'd0, 1'b1);

        // Reset mid-drain.
        cycle(1'b1, 32'h0000_00F0, 1'b1);
        chk("mid_first", 32'(l_out_idx), 32'd4);
        cycle(1'b0, 32'd0, 1'b1);
        chk("mid_second", 32'(l_out_idx), 32'd5);
        #3;
        ctrl_reset = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_valid", 32'(l_out_valid), 32'd0);
        chk("mid_rst_remaining", 32'(l_remaining), 32'd0);
        chk("mid_rst_in_ready", 32'(l_in_ready), 32'd1);
        cycle(1'b0, 32'd0, 1'b1);
        ctrl_reset = 1'b1;
        cycle(1'b1, 32'h0000_0001, 1'b0);
        chk("post_rst_idx", 32'(l_out_idx), 32'd0);
        chk("post_rst_valid", 32'(l_out_valid), 32'd1);
        cycle(1'b0, 32'd0, 1'b1);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 4))
                0: rv = 32'd0;
                1: rv = 32'd1 << $urandom_range(0, 31);
                2: rv = $urandom & $urandom & $urandom;
                3: rv = 32'hFFFF_FFFF;
                default: rv = $urandom;
            endcase
            cycle(1'($urandom_range(0, 1)), rv, ($urandom_range(0, 9) < 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
